slot_game_ctrl: RTL and testbench
=================================

# slot_game_ctrl

Top-level sequencer for the 3x3 slot machine. It holds the player credit and accepts a bet on start. It gates the nine reel counters through per-cell spin enables, snapshots the grid once every reel has stopped, and scores the 8 paylines serially through one shared line evaluator. Winnings are added to credit, and the coin hopper is driven on cash-out with a req/ack handshake.

## Interface
Parameters:
- BET, default 1: credits deducted per accepted start.
- PAY_MULT, default 1: multiplier applied to each winning line's pay.

Ports:
- clk  in  1: system clock, all logic on rising edge.
- clrb  in  1: asynchronous, active-low reset.
- coin_in  in  1: one-cycle pulse per inserted coin.
- start  in  1: one-cycle pulse, request a spin.
- cashout  in  1: one-cycle pulse, request credit payout.
- stop  in  9: one-cycle stop pulses. Bit i = cell i, with i = row*3+col (a1=0 … c3=8).
- reel_sym  in  27: current reel symbols, cell i at [3i+2:3i].
- hopper_ack  in  1: one-cycle pulse, one coin dispensed.
- spin_en  out  9: reel counter enables.
- hopper_req  out  1: level, hopper should dispense.
- credit  out  8: current credit.
- win  out  8: total win of the last spin.
- busy  out  1: high in any state other than IDLE.

## Operation
- States:
  - IDLE → SPIN on start when credit ≥ BET.
  - IDLE → PAY on cashout when credit > 0 and no start is accepted that cycle.
  - SPIN → EVAL when the last spin_en bit clears.
  - EVAL → COMMIT after line 7.
  - COMMIT → IDLE.
  - PAY → IDLE when credit reaches 0.
- Start accepted: credit -= BET, spin_en = 9'h1FF, win cleared to 0.
- Start and cashout in the same cycle: start wins and cashout is dropped.
- SPIN:
  - stop[i] clears spin_en[i]; stops to already-stopped cells are ignored.
  - On the edge where spin_en becomes 0, reel_sym is registered into a snapshot.
  - Multiple stops in one cycle are all honoured.
- Stops outside SPIN are ignored. start and cashout are ignored outside IDLE.
- EVAL walks one line per cycle, line_idx 0..7:
  - Lines 0-2 are rows, 3-5 are columns.
  - Line 6 is the diagonal (0,4,8); line 7 is the anti-diagonal (2,4,6).
- Line pay:
  - Three equal symbols s with s ≤ 4 pay (s+1)*PAY_MULT.
  - Otherwise the line pays 0. Symbols 5-7 never pay.
- win accumulates line pays with saturation at 255.
- COMMIT: credit = min(255, credit + win).
- coin_in:
  - Counted in every state, credit += 1, saturating at 255.
  - Combined with a same-cycle start or ack as a net update: credit + coin − BET or credit + coin − 1.
- PAY:
  - hopper_req = 1 while credit > 0.
  - Each hopper_ack decrements credit by 1.
  - hopper_ack outside PAY is ignored.
- Reset at any time:
  - Clears state to IDLE; credit, win, spin_en, hopper_req, busy and the snapshot to 0.
  - An in-progress spin or payout is abandoned with no refund.

## Timing
- Start pulse sampled at edge k: spin_en = 1FF and busy = 1 from cycle k+1.
- Final stop at edge m: snapshot at edge m; EVAL occupies cycles m+1..m+8; COMMIT at m+9.
- Updated credit visible from m+10, with busy = 0 from m+10.
- win is final from m+9 and held until the next accepted start.
- Cashout at edge k: hopper_req = 1 from k+1.
- In PAY, the ack that drops credit to 0 at edge n gives hopper_req = 0 and state IDLE from n+1.
- If a coin arrives at the same edge as that final ack, credit stays 1 and PAY continues.
- All outputs are registered; no combinational input-to-output paths.

## Structure
- Package slot_pkg holds:
  - State enum: IDLE, SPIN, EVAL, COMMIT, PAY.
  - SYM_W = 3, NCELL = 9, CREDIT_MAX = 255.
  - The 8-entry payline table of cell-index triples.
- Sub-module slot_line_eval: purely combinational; three 3-bit symbols → 8-bit line pay. One instance is shared by all lines via line_idx muxing.
- Reel counters remain external and are enabled by spin_en.

## Test plan
- Reset, 3 coin pulses → credit 3. start → credit 2, spin_en 1FF, busy 1.
- Spin with stops on separate cycles; final snapshot has all cells = 2 → all 8 lines pay 3, win 24, credit 2+24 = 26 at m+10.
- Snapshot rows 1,1,1 / 0,3,4 / 1,2,0 → only line 0 pays 2 → win 2. Also check symbol-7 triples pay 0.
- credit 0, start → ignored, stays IDLE. Then credit 254 with win 5 → credit saturates at 255.
- credit 3, cashout → hopper_req high. 3 acks with a coin_in coinciding with the 2nd ack → 4 acks total needed, then req low and IDLE.
- clrb asserted mid-EVAL and mid-PAY → all outputs 0 immediately. After release, stops and acks are ignored until a new start.

Source files
------------

// File: rtl/slot_pkg.sv
// Shared types and constants for the 3x3 slot machine sequencer.
package slot_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SPIN   = 3'd1,
        EVAL   = 3'd2,
        COMMIT = 3'd3,
        PAY    = 3'd4
    } state_t;

    localparam int SYM_W      = 3;
    localparam int NCELL      = 9;
    localparam int NLINE      = 8;
    localparam int CREDIT_MAX = 255;

    // Payline table. Each 12-bit entry holds three 4-bit cell indices,
    // the first cell of the line in the low nibble. Cell i = row*3+col.
    //   0-2 rows, 3-5 columns, 6 diagonal, 7 anti-diagonal.
    localparam logic [NLINE-1:0][11:0] PAYLINES = {
        12'h642,    // line 7: 2,4,6
        12'h840,    // line 6: 0,4,8
        12'h852,    // line 5: 2,5,8
        12'h741,    // line 4: 1,4,7
        12'h630,    // line 3: 0,3,6
        12'h876,    // line 2: 6,7,8
        12'h543,    // line 1: 3,4,5
        12'h210     // line 0: 0,1,2
    };

    // Cell index of position k (0..2) along payline 'line'.
    function automatic logic [3:0] line_cell(input logic [2:0] line, input logic [1:0] k);
        logic [11:0] entry;
        entry = PAYLINES[line];
        return entry[{k, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/slot_line_eval.sv
// Combinational pay for one payline: three matching low symbols pay (s+1)*PAY_MULT.
module slot_line_eval
    import slot_pkg::*;
#(
    parameter int PAY_MULT = 1
) (
    input  logic [SYM_W-1:0] sym_a,
    input  logic [SYM_W-1:0] sym_b,
    input  logic [SYM_W-1:0] sym_c,
    output logic [7:0]       pay
);

    logic [31:0] prod;

    // Matching triple of symbol 0..4 pays; the product saturates at 8 bits.
    always_comb begin
        pay  = 8'd0;
        prod = (32'(sym_a) + 32'd1) * 32'(PAY_MULT);
        if ((sym_a == sym_b) && (sym_b == sym_c) && (sym_a <= 3'd4)) begin
            pay = (prod > 32'd255) ? 8'hFF : prod[7:0];
        end
    end

endmodule

// File: rtl/slot_game_ctrl.sv
// Slot machine sequencer: credit, spin gating, serial payline scoring, hopper payout.
module slot_game_ctrl
    import slot_pkg::*;
#(
    parameter int BET      = 1,
    parameter int PAY_MULT = 1
) (
    input  logic        clk,
    input  logic        clrb,
    input  logic        coin_in,
    input  logic        start,
    input  logic        cashout,
    input  logic [8:0]  stop,
    input  logic [26:0] reel_sym,
    input  logic        hopper_ack,
    output logic [8:0]  spin_en,
    output logic        hopper_req,
    output logic [7:0]  credit,
    output logic [7:0]  win,
    output logic        busy
);

    state_t              state_reg;
    logic [2:0]          line_idx_reg;
    logic [26:0]         snapshot_reg;

    logic [SYM_W-1:0]    snap_cell [NCELL];
    logic [SYM_W-1:0]    sym_a, sym_b, sym_c;
    logic [7:0]          line_pay;
    logic [7:0]          win_next;
    logic [7:0]          credit_next;
    logic [8:0]          spin_en_next;
    logic                start_ok, pay_ok, ack_ok;

    // Unpack the snapshot into per-cell symbols for the line mux.
    genvar gi;
    generate
        for (gi = 0; gi < NCELL; gi++) begin : g_cell
            assign snap_cell[gi] = snapshot_reg[SYM_W*gi +: SYM_W];
        end
    endgenerate

    // Select the three cells of the line currently being scored.
    always_comb begin
        sym_a = snap_cell[line_cell(line_idx_reg, 2'd0)];
        sym_b = snap_cell[line_cell(line_idx_reg, 2'd1)];
        sym_c = snap_cell[line_cell(line_idx_reg, 2'd2)];
    end

    slot_line_eval #(
        .PAY_MULT (PAY_MULT)
    ) u_line_eval (
        .sym_a (sym_a),
        .sym_b (sym_b),
        .sym_c (sym_c),
        .pay   (line_pay)
    );

    // Next credit as a single net update: coin, committed win, minus bet or dispensed coin.
    always_comb begin
        int unsigned sum;
        int unsigned debit;
        start_ok    = (state_reg == IDLE) && start && (int'(credit) >= BET);
        pay_ok      = (state_reg == IDLE) && cashout && !start_ok && (credit != 8'd0);
        ack_ok      = (state_reg == PAY) && hopper_ack;
        sum         = int'(credit) + (coin_in ? 1 : 0)
                    + ((state_reg == COMMIT) ? int'(win) : 0);
        debit       = start_ok ? BET : (ack_ok ? 1 : 0);
        sum         = sum - debit;
        credit_next = (sum > CREDIT_MAX) ? 8'hFF : sum[7:0];
    end

    // Saturating win accumulation and stop masking.
    always_comb begin
        logic [8:0] wsum;
        wsum         = {1'b0, win} + {1'b0, line_pay};
        win_next     = wsum[8] ? 8'hFF : wsum[7:0];
        spin_en_next = spin_en & ~stop;
    end

    // Main sequencer with registered outputs.
    always_ff @(posedge clk or negedge clrb) begin
        if (!clrb) begin
            state_reg    <= IDLE;
            line_idx_reg <= 3'd0;
            snapshot_reg <= '0;
            spin_en      <= '0;
            hopper_req   <= 1'b0;
            credit       <= 8'd0;
            win          <= 8'd0;
            busy         <= 1'b0;
        end else begin
            credit <= credit_next;
            case (state_reg)
                IDLE: begin
                    if (start_ok) begin
                        state_reg <= SPIN;
                        spin_en   <= 9'h1FF;
                        win       <= 8'd0;
                        busy      <= 1'b1;
                    end else if (pay_ok) begin
                        state_reg  <= PAY;
                        hopper_req <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                SPIN: begin
                    spin_en <= spin_en_next;
                    if (spin_en_next == 9'd0) begin
                        snapshot_reg <= reel_sym;
                        line_idx_reg <= 3'd0;
                        state_reg    <= EVAL;
                    end
                end
                EVAL: begin
                    win          <= win_next;
                    line_idx_reg <= line_idx_reg + 3'd1;
                    if (line_idx_reg == 3'd7) begin
                        state_reg <= COMMIT;
                    end
                end
                COMMIT: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
                PAY: begin
                    if (credit_next == 8'd0) begin
                        state_reg  <= IDLE;
                        hopper_req <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    spin_en    <= '0;
                    hopper_req <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slot_game_ctrl.sv
// Directed self-checking bench for slot_game_ctrl.
module tb_slot_game_ctrl;

    logic        clk = 1'b0;
    logic        clrb = 1'b0;
    logic        coin_in = 1'b0;
    logic        start = 1'b0;
    logic        cashout = 1'b0;
    logic [8:0]  stop = '0;
    logic [26:0] reel_sym = '0;
    logic        hopper_ack = 1'b0;
    logic [8:0]  spin_en;
    logic        hopper_req;
    logic [7:0]  credit;
    logic [7:0]  win;
    logic        busy;

    int checks = 0;
    int failures = 0;

    slot_game_ctrl #(
        .BET      (1),
        .PAY_MULT (1)
    ) dut (
        .clk        (clk),
        .clrb       (clrb),
        .coin_in    (coin_in),
        .start      (start),
        .cashout    (cashout),
        .stop       (stop),
        .reel_sym   (reel_sym),
        .hopper_ack (hopper_ack),
        .spin_en    (spin_en),
        .hopper_req (hopper_req),
        .credit     (credit),
        .win        (win),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] cr, input logic [7:0] w,
                             input logic [8:0] se, input logic hr, input logic b);
        check({tag, ".credit"}, 32'(credit), 32'(cr));
        check({tag, ".win"}, 32'(win), 32'(w));
        check({tag, ".spin_en"}, 32'(spin_en), 32'(se));
        check({tag, ".hopper_req"}, 32'(hopper_req), 32'(hr));
        check({tag, ".busy"}, 32'(busy), 32'(b));
        $display("txn %s credit=%0d win=%0d spin_en=%h req=%0b busy=%0b",
                 tag, credit, win, spin_en, hopper_req, busy);
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic coins(input int n);
        coin_in = 1'b1;
        repeat (n) step();
        coin_in = 1'b0;
    endtask

    task automatic do_reset();
        clrb = 1'b0;
        step();
        clrb = 1'b1;
    endtask

    // Start a spin, stop all reels at once with the given grid, run to m+10.
    task automatic spin_all(input string tag, input logic [26:0] syms);
        start = 1'b1;
        step();
        start = 1'b0;
        check({tag, ".win_cleared"}, 32'(win), 32'd0);
        reel_sym = syms;
        stop = 9'h1FF;
        step();
        stop = 9'h000;
        repeat (9) step();
    endtask

    initial begin
        // Reset state
        step();
        check_all("reset", 8'd0, 8'd0, 9'h000, 1'b0, 1'b0);
        clrb = 1'b1;

        // Three coins, then a start
        coins(3);
        check("coins3", 32'(credit), 32'd3);
        start = 1'b1;
        step();
        start = 1'b0;
        check_all("start", 8'd2, 8'd0, 9'h1FF, 1'b0, 1'b1);

        // Stops on separate cycles, including a repeat stop to an already-stopped cell
        stop = 9'h00F;
        step();
        stop = 9'h000;
        check("stop_a", 32'(spin_en), 32'h1F0);
        stop = 9'h0F1;
        step();
        stop = 9'h000;
        check("stop_b", 32'(spin_en), 32'h100);
        reel_sym = {9{3'd2}};
        stop = 9'h100;
        step();                         // edge m
        stop = 9'h000;
        check_all("final_stop", 8'd2, 8'd0, 9'h000, 1'b0, 1'b1);
        repeat (8) step();              // after edge m+8: cycle m+9 (COMMIT)
        check_all("all2_win", 8'd2, 8'd24, 9'h000, 1'b0, 1'b1);
        step();                         // cycle m+10
        check_all("all2_commit", 8'd26, 8'd24, 9'h000, 1'b0, 1'b0);

        // Stops in IDLE are ignored
        stop = 9'h1FF;
        step();
        stop = 9'h000;
        check_all("stop_idle", 8'd26, 8'd24, 9'h000, 1'b0, 1'b0);

        // Rows 1,1,1 / 0,3,4 / 1,2,0 : only line 0 pays 2
        spin_all("row0", {3'd0, 3'd2, 3'd1, 3'd4, 3'd3, 3'd0, 3'd1, 3'd1, 3'd1});
        check_all("row0_done", 8'd27, 8'd2, 9'h000, 1'b0, 1'b0);

        // Symbol 7 everywhere pays nothing
        spin_all("sym7", {9{3'd7}});
        check_all("sym7_done", 8'd26, 8'd0, 9'h000, 1'b0, 1'b0);

        // Start with zero credit is ignored
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        check_all("start_nocredit", 8'd0, 8'd0, 9'h000, 1'b0, 1'b0);

        // Coin saturation, then win saturation on commit: 254 + 5 -> 255
        coins(256);
        check("coin_sat", 32'(credit), 32'd255);
        spin_all("sat", {3'd6, 3'd5, 3'd3, 3'd2, 3'd1, 3'd0, 3'd4, 3'd4, 3'd4});
        check_all("sat_done", 8'd255, 8'd5, 9'h000, 1'b0, 1'b0);

        // Cashout: ack in IDLE ignored, coins mid-payout extend it
        do_reset();
        coins(3);
        hopper_ack = 1'b1;
        step();
        hopper_ack = 1'b0;
        check("ack_idle", 32'(credit), 32'd3);
        cashout = 1'b1;
        step();
        cashout = 1'b0;
        check_all("cashout", 8'd3, 8'd0, 9'h000, 1'b1, 1'b1);
        hopper_ack = 1'b1;
        step();
        check("ack1", 32'(credit), 32'd2);
        coin_in = 1'b1;
        step();
        coin_in = 1'b0;
        check("ack2_coin", 32'(credit), 32'd2);
        step();
        check_all("ack3", 8'd1, 8'd0, 9'h000, 1'b1, 1'b1);
        coin_in = 1'b1;
        step();
        coin_in = 1'b0;
        check_all("ack_final_coin", 8'd1, 8'd0, 9'h000, 1'b1, 1'b1);
        step();
        hopper_ack = 1'b0;
        check_all("pay_done", 8'd0, 8'd0, 9'h000, 1'b0, 1'b0);

        // Start and cashout together: start wins
        coins(2);
        start = 1'b1;
        cashout = 1'b1;
        step();
        start = 1'b0;
        cashout = 1'b0;
        check_all("start_vs_cashout", 8'd1, 8'd0, 9'h1FF, 1'b0, 1'b1);
        reel_sym = {9{3'd7}};
        stop = 9'h1FF;
        step();
        stop = 9'h000;
        repeat (9) step();
        check_all("svc_done", 8'd1, 8'd0, 9'h000, 1'b0, 1'b0);

        // Reset mid-EVAL clears everything without a clock edge
        coins(2);
        start = 1'b1;
        step();
        start = 1'b0;
        reel_sym = {9{3'd2}};
        stop = 9'h1FF;
        step();
        stop = 9'h000;
        repeat (3) step();
        check_all("mid_eval", 8'd2, 8'd9, 9'h000, 1'b0, 1'b1);
        #1 clrb = 1'b0;
        #1;
        check_all("rst_eval", 8'd0, 8'd0, 9'h000, 1'b0, 1'b0);
        step();
        clrb = 1'b1;
        stop = 9'h1FF;
        hopper_ack = 1'b1;
        step();
        stop = 9'h000;
        hopper_ack = 1'b0;
        check_all("post_rst_eval", 8'd0, 8'd0, 9'h000, 1'b0, 1'b0);

        // Reset mid-PAY
        coins(3);
        cashout = 1'b1;
        step();
        cashout = 1'b0;
        hopper_ack = 1'b1;
        step();
        hopper_ack = 1'b0;
        check_all("mid_pay", 8'd2, 8'd0, 9'h000, 1'b1, 1'b1);
        #1 clrb = 1'b0;
        #1;
        check_all("rst_pay", 8'd0, 8'd0, 9'h000, 1'b0, 1'b0);
        step();
        clrb = 1'b1;
        hopper_ack = 1'b1;
        step();
        hopper_ack = 1'b0;
        coin_in = 1'b1;
        step();
        coin_in = 1'b0;
        check_all("post_rst_pay", 8'd1, 8'd0, 9'h000, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
